divider_arbiter: RTL and testbench
==================================

// Module: divider_arbiter
// PURPOSE
//  Shares one sign-magnitude fixed-point divider between NREQ requesters using round-robin arbitration.
//  Latches the granted operands, pulses the divider start, and waits for the complete flag with a timeout.
//  Returns the quotient, requester id and an error code on a single valid/ready response bus.
//  Sits between the client blocks and the fixed-point divider core (start/complete protocol).
// PARAMETERS
//  N           32   operand/quotient width; bit N-1 = sign, bits N-2:0 = magnitude
//  NREQ        4    number of requesters (>=2)
//  IDW         2    width of rsp_id; must satisfy 2**IDW >= NREQ
//  TIMEOUT_CYC 255  maximum WAIT cycles before the operation is aborted
//  CNT_W       8    timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//  clk           in   1       system clock, rising edge
//  rst_n         in   1       synchronous reset, active low
//  req_valid     in   NREQ    per-requester request valid
//  req_ready     out  NREQ    per-requester accept; at most one bit high
//  req_dividend  in   NREQ*N  dividend of requester i in bits [i*N +: N]
//  req_divisor   in   NREQ*N  divisor of requester i in bits [i*N +: N]
//  rsp_valid     out  1       response valid
//  rsp_ready     in   1       response accepted by the consumer
//  rsp_id        out  IDW     index of the requester that owns the response
//  rsp_quotient  out  N       quotient, same format and Q as the operands
//  rsp_err       out  2       00 ok, 01 divide-by-zero, 10 timeout
//  div_start     out  1       one-cycle start pulse to the divider
//  div_dividend  out  N       divider operand, held stable from ISSUE to the end of WAIT
//  div_divisor   out  N       divider operand, held stable from ISSUE to the end of WAIT
//  div_quotient  in   N       divider result
//  div_complete  in   1       divider done flag
//  busy          out  1       high whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge), regardless of state:
//   - state becomes IDLE; rr_ptr=0; timeout counter=0; complete-history register=0
//   - all outputs become 0, including the operand and response registers
//   - an in-flight divider result is discarded; div_complete is ignored outside WAIT
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE:
//   - grant g = first set req_valid bit at or after rr_ptr, searching modulo NREQ
//   - req_ready[g]=1 combinationally in the same cycle; the handshake completes in that cycle
//   - latch the operands and g
//   - if the divisor magnitude (bits N-2:0) is 0, go to RESP with err=01
//     (the -0 divisor 1000..0 also counts as zero)
//   - otherwise go to ISSUE
//   - req_ready is 0 in every other state
//  ISSUE:
//   - div_start=1 for exactly this cycle; clear the timeout counter; go to WAIT
//  WAIT:
//   - a completion is a rising edge of div_complete: div_complete=1 while the registered previous value is 0
//   - on a completion: capture div_quotient, set err=00, go to RESP
//   - otherwise, if counter == TIMEOUT_CYC-1: set quotient=0, err=10, go to RESP
//   - otherwise increment the counter
//   - a completion in the same cycle as the timeout wins
//  RESP:
//   - rsp_valid=1; rsp_id, rsp_quotient and rsp_err are held stable until rsp_valid && rsp_ready
//   - on that handshake: rr_ptr = (g+1) mod NREQ, go to IDLE
//   - the next grant can occur in the cycle after the handshake
//  Divide-by-zero response value:
//   - sign = dividend sign XOR divisor sign; magnitude = all ones (saturated)
//   - no div_start is issued
//  Latency (accept in cycle T):
//   - div_start is high in T+1
//   - a completion in cycle C gives rsp_valid from C+1
//   - divide-by-zero gives rsp_valid at T+1
//  Arbitration is fair: a requester holding req_valid is granted within NREQ grants.
// TESTING
//  1) N=32, Q=16; req0 dividend 0x00060000, divisor 0x00020000; model latency 20 cycles
//     -> exactly one div_start; rsp_quotient 0x00030000, rsp_id 0, rsp_err 00.
//  2) All four req_valid high and held -> grant order 0,1,2,3; rsp_id follows the same order; one div_start per grant.
//  3) req2 dividend 0x00010000, divisor 0x80000000
//     -> no div_start; rsp_valid at T+1; rsp_quotient 0xFFFFFFFF, rsp_err 01.
//  4) TIMEOUT_CYC=16, model never completes -> rsp_valid 17 cycles after div_start; rsp_quotient 0, rsp_err 10.
//  5) rsp_ready held low 10 cycles while req1 is valid -> rsp fields stable, req_ready all 0, no new div_start.
//  6) rst_n low for 1 cycle in mid-WAIT -> all outputs 0 next cycle; the late div_complete is ignored;
//     the next req0 is served normally with rr_ptr=0.

Source files
------------

// File: rtl/divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : divider_arbiter
// Brief   : Round-robin front end that shares one start/complete fixed-point
//           divider between NREQ requesters and returns quotient, owner id
//           and error code on a single valid/ready response bus.
// Revision: 1.0 - initial release
// ============================================================================
module divider_arbiter #(
  parameter int N           = 32,
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_dividend,
  input  logic [NREQ*N-1:0] req_divisor,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_quotient,
  output logic [1:0]        rsp_err,
  output logic              div_start,
  output logic [N-1:0]      div_dividend,
  output logic [N-1:0]      div_divisor,
  input  logic [N-1:0]      div_quotient,
  input  logic              div_complete,
  output logic              busy
);

  localparam logic [1:0]       c_err_ok      = 2'b00;
  localparam logic [1:0]       c_err_div0    = 2'b01;
  localparam logic [1:0]       c_err_timeout = 2'b10;
  localparam logic [CNT_W-1:0] c_cnt_last    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDW-1:0]   c_id_last     = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_grant;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cmp_prev;
  logic             r_div_start;
  logic [N-1:0]     r_div_dividend;
  logic [N-1:0]     r_div_divisor;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [N-1:0]     r_rsp_quotient;
  logic [1:0]       r_rsp_err;

  logic             w_hi_found;
  logic [IDW-1:0]   w_hi_idx;
  logic             w_lo_found;
  logic [IDW-1:0]   w_lo_idx;
  logic             w_grant_found;
  logic [IDW-1:0]   w_grant_idx;
  logic [N-1:0]     w_sel_dividend;
  logic [N-1:0]     w_sel_divisor;
  logic [NREQ-1:0]  w_req_ready;
  logic             w_cmp_rise;
  logic             w_div_zero;

  // Round-robin search: lowest valid index at/after the pointer, else lowest overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IDW'(i);
        if (IDW'(i) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDW'(i);
        end
      end
    end
    w_grant_found = w_hi_found | w_lo_found;
    w_grant_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  // Operand mux for the candidate grant and the one-hot ready vector (IDLE only).
  always_comb begin
    w_sel_dividend = '0;
    w_sel_divisor  = '0;
    w_req_ready    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == IDW'(i)) begin
        w_sel_dividend = req_dividend[i*N +: N];
        w_sel_divisor  = req_divisor[i*N +: N];
      end
      w_req_ready[i] = (r_state == ST_IDLE) && w_grant_found && (w_grant_idx == IDW'(i));
    end
  end

  // Both +0 and -0 divisors count as zero: only the magnitude matters.
  assign w_div_zero = (w_sel_divisor[N-2:0] == '0);

  // A completion is a rising edge of the divider done flag.
  assign w_cmp_rise = div_complete & ~r_cmp_prev;

  // Main control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_rr_ptr       <= '0;
      r_grant        <= '0;
      r_cnt          <= '0;
      r_cmp_prev     <= 1'b0;
      r_div_start    <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= '0;
      r_rsp_quotient <= '0;
      r_rsp_err      <= c_err_ok;
    end else begin
      r_cmp_prev  <= div_complete;
      r_div_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_found) begin
            r_grant        <= w_grant_idx;
            r_div_dividend <= w_sel_dividend;
            r_div_divisor  <= w_sel_divisor;
            if (w_div_zero) begin
              // Saturated magnitude with the product sign; the divider is never started.
              r_rsp_quotient <= {w_sel_dividend[N-1] ^ w_sel_divisor[N-1], {(N-1){1'b1}}};
              r_rsp_err      <= c_err_div0;
              r_rsp_id       <= w_grant_idx;
              r_rsp_valid    <= 1'b1;
              r_state        <= ST_RESP;
            end else begin
              r_div_start <= 1'b1;
              r_state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion is tested first so it wins over a simultaneous timeout.
          if (w_cmp_rise) begin
            r_rsp_quotient <= div_quotient;
            r_rsp_err      <= c_err_ok;
            r_rsp_id       <= r_grant;
            r_rsp_valid    <= 1'b1;
            r_state        <= ST_RESP;
          end else if (r_cnt == c_cnt_last) begin
            r_rsp_quotient <= '0;
            r_rsp_err      <= c_err_timeout;
            r_rsp_id       <= r_grant;
            r_rsp_valid    <= 1'b1;
            r_state        <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= (r_grant == c_id_last) ? '0 : r_grant + 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = w_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_quotient = r_rsp_quotient;
  assign rsp_err      = r_rsp_err;
  assign div_start    = r_div_start;
  assign div_dividend = r_div_dividend;
  assign div_divisor  = r_div_divisor;
  assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_divider_arbiter
// Brief   : Scoreboard bench for divider_arbiter with an emulated divider core,
//           round-robin reference model and randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_divider_arbiter;

  localparam int N     = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int TMO   = 24;
  localparam int CNT_W = 5;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_dividend;
  logic [NREQ*N-1:0] req_divisor;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_quotient;
  logic [1:0]        rsp_err;
  logic              div_start;
  logic [N-1:0]      div_dividend;
  logic [N-1:0]      div_divisor;
  logic [N-1:0]      div_quotient;
  logic              div_complete;
  logic              busy;

  divider_arbiter #(
    .N(N), .NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYC(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_quotient(rsp_quotient), .rsp_err(rsp_err),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_complete(div_complete),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks;
  int n_fail;
  int n_starts;
  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_starts = 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Emulated divider core: sign-magnitude Q16 quotient, magnitude saturated.
  function automatic logic [31:0] fx_div(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] num;
    logic [63:0] q;
    num = {33'd0, a[30:0]} << 16;
    q   = num / {33'd0, b[30:0]};
    if (q > 64'h7FFF_FFFF) q = 64'h7FFF_FFFF;
    return {a[31] ^ b[31], q[30:0]};
  endfunction

  typedef struct {
    int         id;
    logic [31:0] q;
    logic [1:0]  err;
    int         first;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
  } start_t;

  rsp_t   exp_rsp[$];
  start_t exp_start[$];
  int     grant_log[$];

  // Per-requester pending operations; latency 0 means the divider never completes.
  logic [31:0] opq_a[NREQ][$];
  logic [31:0] opq_b[NREQ][$];
  int          opq_lat[NREQ][$];

  logic [NREQ-1:0] drv_v;
  logic [31:0]     drv_a[NREQ];
  logic [31:0]     drv_b[NREQ];
  int              drv_lat[NREQ];
  int              model_ptr;
  int              bp_mode;

  task automatic push_op(input int i, input logic [31:0] a, input logic [31:0] b, input int lat);
    opq_a[i].push_back(a);
    opq_b[i].push_back(b);
    opq_lat[i].push_back(lat);
  endtask

  function automatic bit all_drained();
    bit r;
    r = (drv_v == '0) && (exp_rsp.size() == 0) && !busy;
    for (int i = 0; i < NREQ; i++) if (opq_a[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (k < bound && !all_drained()) begin
      @(negedge clk);
      k++;
    end
    if (k >= bound) flag_fail("wait_idle_timeout");
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},    req_ready,    0);
    check({tag, "_rsp_valid"},    rsp_valid,    0);
    check({tag, "_rsp_id"},       rsp_id,       0);
    check({tag, "_rsp_quotient"}, rsp_quotient, 0);
    check({tag, "_rsp_err"},      rsp_err,      0);
    check({tag, "_div_start"},    div_start,    0);
    check({tag, "_div_dividend"}, div_dividend, 0);
    check({tag, "_div_divisor"},  div_divisor,  0);
    check({tag, "_busy"},         busy,         0);
  endtask

  // Request driver plus reference arbiter: predicts each grant and the response it owes.
  initial begin
    int          g;
    int          ga;
    int          t;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [NREQ-1:0] expv;
    drv_v        = '0;
    model_ptr    = 0;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    for (int i = 0; i < NREQ; i++) begin
      drv_a[i] = '0; drv_b[i] = '0; drv_lat[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!drv_v[i] && opq_a[i].size() > 0) begin
          drv_v[i]   = 1'b1;
          drv_a[i]   = opq_a[i].pop_front();
          drv_b[i]   = opq_b[i].pop_front();
          drv_lat[i] = opq_lat[i].pop_front();
        end
        req_valid[i]          = drv_v[i];
        req_dividend[i*N +: N] = drv_a[i];
        req_divisor[i*N +: N]  = drv_b[i];
      end
      @(negedge clk);
      if (rst_n && (req_valid & req_ready) != '0) begin
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && req_valid[(model_ptr + k) % NREQ]) g = (model_ptr + k) % NREQ;
        end
        expv = '0;
        if (g >= 0) expv[g] = 1'b1;
        check("grant_rr", req_ready, expv);
        ga = 0;
        for (int k = NREQ - 1; k >= 0; k--) if (req_valid[k] && req_ready[k]) ga = k;
        grant_log.push_back(ga);
        model_ptr = (ga + 1) % NREQ;
        drv_v[ga] = 1'b0;
        a   = drv_a[ga];
        b   = drv_b[ga];
        lat = drv_lat[ga];
        t   = cyc;
        if (b[30:0] == 31'd0) begin
          exp_rsp.push_back('{ga, {a[31] ^ b[31], 31'h7FFF_FFFF}, 2'b01, t + 1});
        end else begin
          exp_start.push_back('{t + 1, a, b, lat});
          if (lat == 0 || lat > TMO)
            exp_rsp.push_back('{ga, 32'h0, 2'b10, t + TMO + 2});
          else
            exp_rsp.push_back('{ga, fx_div(a, b), 2'b00, t + lat + 2});
        end
      end
    end
  end

  // Response consumer: readiness pattern selected by bp_mode.
  initial begin
    bp_mode   = 0;
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Divider core emulation: checks each start against the scoreboard, completes after lat cycles.
  initial begin
    int          cnt;
    logic [31:0] ca;
    logic [31:0] cb;
    start_t      st;
    cnt          = 0;
    ca           = '0;
    cb           = '0;
    div_complete = 1'b0;
    div_quotient = '0;
    forever begin
      @(negedge clk);
      div_complete = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (busy) begin
            check("operand_hold_dividend", div_dividend, ca);
            check("operand_hold_divisor",  div_divisor,  cb);
          end
          div_complete = 1'b1;
          div_quotient = fx_div(ca, cb);
        end
      end
      if (rst_n && div_start) begin
        n_starts++;
        if (exp_start.size() == 0) begin
          flag_fail("unexpected_div_start");
        end else begin
          st = exp_start.pop_front();
          check("start_cycle",  cyc,          st.cyc);
          check("start_dividend", div_dividend, st.a);
          check("start_divisor",  div_divisor,  st.b);
          ca  = st.a;
          cb  = st.b;
          cnt = st.lat;
        end
      end
    end
  end

  // Response monitor: latency, hold stability under backpressure and payload.
  initial begin
    logic           pv;
    logic           pready;
    logic [IDW-1:0] pid;
    logic [31:0]    pq;
    logic [1:0]     perr;
    rsp_t           e;
    pv = 1'b0; pready = 1'b0; pid = '0; pq = '0; perr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (busy) check("ready_while_busy", req_ready, 0);
        if (rsp_valid && !pv) begin
          if (exp_rsp.size() == 0) flag_fail("unexpected_rsp");
          else check("rsp_latency", cyc, exp_rsp[0].first);
        end
        if (rsp_valid && pv && !pready) begin
          check("hold_id",       rsp_id,       pid);
          check("hold_quotient", rsp_quotient, pq);
          check("hold_err",      rsp_err,      perr);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp.size() == 0) begin
            flag_fail("rsp_without_expectation");
          end else begin
            e = exp_rsp.pop_front();
            check("rsp_id",       rsp_id,       e.id);
            check("rsp_quotient", rsp_quotient, e.q);
            check("rsp_err",      rsp_err,      e.err);
          end
        end
        pv = rsp_valid; pready = rsp_ready; pid = rsp_id; pq = rsp_quotient; perr = rsp_err;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int s;
    int k;
    int base;
    logic [31:0] rb;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    // All four requesters valid together: grants rotate 0,1,2,3.
    for (int i = 0; i < NREQ; i++) push_op(i, $urandom, {1'b0, 31'($urandom_range(1, 32'h7FFF_FFFF))}, 4);
    s = n_starts;
    wait_idle(400);
    for (int i = 0; i < NREQ; i++) check("rr_order", grant_log[i], i);
    check("rr_starts", n_starts - s, NREQ);

    // Single Q16 division 6.0 / 2.0 with a slow divider.
    s = n_starts;
    push_op(0, 32'h0006_0000, 32'h0002_0000, 20);
    wait_idle(200);
    check("single_starts", n_starts - s, 1);

    // Divide by -0: saturated negative result, divider untouched.
    s = n_starts;
    push_op(2, 32'h0001_0000, 32'h8000_0000, 5);
    wait_idle(100);
    check("div0_starts", n_starts - s, 0);

    // Timeout, completion exactly at the timeout cycle, and one cycle too late.
    push_op(1, 32'h0010_0000, 32'h0004_0000, 0);
    wait_idle(200);
    push_op(1, 32'h8010_0000, 32'h0004_0000, TMO);
    wait_idle(200);
    push_op(3, 32'h0010_0000, 32'h8004_0000, TMO + 1);
    wait_idle(200);

    // Backpressure: response held while another requester waits.
    bp_mode = 2;
    push_op(0, 32'h0009_0000, 32'h0003_0000, 3);
    k = 0;
    while (k < 60 && !rsp_valid) begin @(negedge clk); k++; end
    if (k >= 60) flag_fail("bp_rsp_never_valid");
    push_op(1, 32'h0004_0000, 32'h0002_0000, 3);
    s = n_starts;
    repeat (10) @(negedge clk);
    check("bp_req1_waiting", req_valid[1], 1);
    check("bp_req_ready",    req_ready,    0);
    check("bp_no_start",     n_starts - s, 0);
    bp_mode = 0;
    wait_idle(200);

    // Reset in mid-WAIT: pointer returns to 0 and the late completion is ignored.
    push_op(2, 32'h0001_0000, 32'h0001_0000, 3);
    wait_idle(100);
    s = n_starts;
    push_op(3, 32'h0005_0000, 32'h0001_0000, 15);
    k = 0;
    while (k < 20 && n_starts == s) begin @(negedge clk); k++; end
    if (k >= 20) flag_fail("reset_test_no_start");
    repeat (4) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_rsp.delete();
    model_ptr = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midwait");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("stale_busy",  busy,      0);
    check("stale_valid", rsp_valid, 0);
    base = grant_log.size();
    push_op(0, 32'h0008_0000, 32'h0002_0000, 3);
    push_op(3, 32'h0003_0000, 32'h0002_0000, 3);
    wait_idle(200);
    check("post_reset_first",  grant_log[base],     0);
    check("post_reset_second", grant_log[base + 1], 3);

    // Randomized traffic with random backpressure.
    bp_mode = 1;
    for (int n = 0; n < 40; n++) begin
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb[30:0] = '0;
      push_op($urandom_range(0, NREQ - 1), $urandom, rb,
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_idle(6000);
    bp_mode = 0;

    check("pending_starts", exp_start.size(), 0);
    check("pending_rsps",   exp_rsp.size(),   0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
